// File: rtl/tron_plot_scheduler_if.sv
// Pixel-port bundle between the Tron game logic (master) and the plot scheduler (slave).
// Carries the tick/clear requests and player positions in, and the adapter write port and status out.
interface tron_plot_scheduler_if;
    logic        tick;
    logic        clear_req;
    logic [14:0] p1;
    logic [14:0] p2;
    logic [14:0] p3;
    logic [14:0] p4;
    logic [3:0]  alive;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        frame_done;
    logic        oob_err;

    modport master (
        output tick, clear_req, p1, p2, p3, p4, alive,
        input  x, y, colour, plot, busy, frame_done, oob_err
    );

    modport slave (
        input  tick, clear_req, p1, p2, p3, p4, alive,
        output x, y, colour, plot, busy, frame_done, oob_err
    );
endinterface

// File: rtl/tron_plot_scheduler.sv
// Tick-driven scheduler for the single VGA adapter write port: plots four player heads per
// game tick in fixed order, or sweeps the whole screen to the background colour on request.
module tron_plot_scheduler #(
    parameter int         WIDTH          = 160,
    parameter int         HEIGHT         = 120,
    parameter logic [2:0] BG_COLOUR      = 3'b000,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input logic                   CLOCK_50,
    input logic                   resetn,
    tron_plot_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    function automatic logic [2:0] player_colour(input logic [1:0] idx);
        logic [2:0] c;
        case (idx)
            2'd0:    c = 3'b001;
            2'd1:    c = 3'b010;
            2'd2:    c = 3'b100;
            2'd3:    c = 3'b110;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  cx_r, cx_s;
    logic [6:0]  cy_r, cy_s;
    logic [1:0]  idx_r, idx_s;
    logic        pend_tick_r, pend_tick_s;
    logic        pend_clr_r, pend_clr_s;
    logic [14:0] snap_r [4];
    logic [3:0]  snap_alive_r;
    logic        snap_en_s;

    logic [7:0]  x_r, x_s;
    logic [6:0]  y_r, y_s;
    logic [2:0]  colour_r, colour_s;
    logic        plot_r, plot_s;
    logic        busy_r, busy_s;
    logic        frame_done_r, frame_done_s;
    logic        oob_err_r, oob_s;

    logic [14:0] cur_pos_s;
    logic [7:0]  cur_x_s;
    logic [6:0]  cur_y_s;
    logic        in_range_s;

    // Current draw slot decoded from the frozen snapshot
    always_comb begin
        cur_pos_s  = snap_r[idx_r];
        cur_x_s    = cur_pos_s[14:7];
        cur_y_s    = cur_pos_s[6:0];
        in_range_s = ({1'b0, cur_x_s} < 9'(WIDTH)) && ({1'b0, cur_y_s} < 8'(HEIGHT));
    end

    // Next-state, pending-request and pixel-output decode
    always_comb begin
        state_s      = state_r;
        cx_s         = cx_r;
        cy_s         = cy_r;
        idx_s        = idx_r;
        pend_tick_s  = pend_tick_r;
        pend_clr_s   = pend_clr_r;
        snap_en_s    = 1'b0;
        x_s          = x_r;
        y_s          = y_r;
        colour_s     = colour_r;
        plot_s       = 1'b0;
        busy_s       = 1'b0;
        frame_done_s = 1'b0;
        oob_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear_req || pend_clr_r) begin
                    state_s    = ST_CLEAR;
                    cx_s       = 8'd0;
                    cy_s       = 7'd0;
                    pend_clr_s = 1'b0;
                    // a tick losing to the clear is remembered for after the sweep
                    pend_tick_s = pend_tick_r | bus.tick;
                end else if (bus.tick || pend_tick_r) begin
                    state_s     = ST_DRAW;
                    idx_s       = 2'd0;
                    snap_en_s   = 1'b1;
                    pend_tick_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                x_s         = cx_r;
                y_s         = cy_r;
                colour_s    = BG_COLOUR;
                plot_s      = 1'b1;
                busy_s      = 1'b1;
                pend_tick_s = pend_tick_r | bus.tick;
                if (cx_r == X_LAST) begin
                    cx_s = 8'd0;
                    if (cy_r == Y_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        cy_s = cy_r + 7'd1;
                    end
                end else begin
                    cx_s = cx_r + 8'd1;
                end
            end
            ST_DRAW: begin
                x_s         = cur_x_s;
                y_s         = cur_y_s;
                colour_s    = player_colour(idx_r);
                plot_s      = snap_alive_r[idx_r] & in_range_s;
                oob_s       = snap_alive_r[idx_r] & ~in_range_s;
                busy_s      = 1'b1;
                pend_tick_s = pend_tick_r | bus.tick;
                pend_clr_s  = pend_clr_r | bus.clear_req;
                if (idx_r == 2'd3) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s = idx_r + 2'd1;
                end
            end
            ST_DONE: begin
                frame_done_s = 1'b1;
                pend_tick_s  = pend_tick_r | bus.tick;
                pend_clr_s   = pend_clr_r | bus.clear_req;
                state_s      = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, pending flags and player snapshot
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cx_r         <= 8'd0;
            cy_r         <= 7'd0;
            idx_r        <= 2'd0;
            pend_tick_r  <= 1'b0;
            pend_clr_r   <= 1'b0;
            snap_alive_r <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= 15'd0;
            end
        end else begin
            state_r     <= state_s;
            cx_r        <= cx_s;
            cy_r        <= cy_s;
            idx_r       <= idx_s;
            pend_tick_r <= pend_tick_s;
            pend_clr_r  <= pend_clr_s;
            if (snap_en_s) begin
                snap_r[0]    <= bus.p1;
                snap_r[1]    <= bus.p2;
                snap_r[2]    <= bus.p3;
                snap_r[3]    <= bus.p4;
                snap_alive_r <= bus.alive;
            end
        end
    end

    // Registered adapter port and status outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x_r          <= 8'd0;
            y_r          <= 7'd0;
            colour_r     <= 3'd0;
            plot_r       <= 1'b0;
            busy_r       <= CLEAR_ON_RESET;
            frame_done_r <= 1'b0;
            oob_err_r    <= 1'b0;
        end else begin
            x_r          <= x_s;
            y_r          <= y_s;
            colour_r     <= colour_s;
            plot_r       <= plot_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
            oob_err_r    <= oob_err_r | oob_s;
        end
    end

    assign bus.x          = x_r;
    assign bus.y          = y_r;
    assign bus.colour     = colour_r;
    assign bus.plot       = plot_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;
    assign bus.oob_err    = oob_err_r;

endmodule

// File: tb/tb_tron_plot_scheduler.sv
// Scoreboard bench for tron_plot_scheduler: every plot/frame_done output event is popped
// from an expected-event queue filled as ticks and clear requests are driven.
module tb_tron_plot_scheduler;

    logic CLOCK_50;
    logic resetn;

    tron_plot_scheduler_if bus();

    tron_plot_scheduler dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // event word: {frame_done, plot, x[7:0], y[6:0], colour[2:0]}
    logic [19:0] exp_q [$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          pix_cnt  = 0;
    logic [2:0]  pcol [4] = '{3'b001, 3'b010, 3'b100, 3'b110};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_sweep();
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                exp_q.push_back({2'b01, 8'(xx), 7'(yy), 3'b000});
            end
        end
        exp_q.push_back({2'b10, 8'd159, 7'd119, 3'b000});
    endtask

    task automatic push_frame(input logic [14:0] a, input logic [14:0] b,
                              input logic [14:0] c, input logic [14:0] d,
                              input logic [3:0] al);
        logic [14:0] p [4];
        p = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            if (al[i] && (p[i][14:7] < 8'd160) && (p[i][6:0] < 7'd120)) begin
                exp_q.push_back({2'b01, p[i], pcol[i]});
            end
        end
        exp_q.push_back({2'b10, d, 3'b110});
    endtask

    // Output monitor: pops one expected event per plot or frame_done cycle
    always @(negedge CLOCK_50) begin
        logic [19:0] obs;
        if (resetn && (bus.plot || bus.frame_done)) begin
            obs = {bus.frame_done, bus.plot, bus.x, bus.y, bus.colour};
            if (bus.plot) pix_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("sb_event", 32'(obs), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_done && n < limit);
        chk("done_timeout", 32'(bus.frame_done), 32'd1);
    endtask

    // Tick in IDLE, then check fixed latency of busy and frame_done
    task automatic tick_frame(input string tag);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
            if (k == 4) begin
                chk({tag, "_busy4"}, 32'(bus.busy), 32'd1);
                chk({tag, "_done4"}, 32'(bus.frame_done), 32'd0);
            end
            if (k == 5) begin
                chk({tag, "_done5"}, 32'(bus.frame_done), 32'd1);
                chk({tag, "_busy5"}, 32'(bus.busy), 32'd0);
            end
        end
        step();
    endtask

    initial begin
        int n;
        int base;
        resetn        = 1'b0;
        bus.tick      = 1'b0;
        bus.clear_req = 1'b0;
        bus.p1        = 15'd0;
        bus.p2        = 15'd0;
        bus.p3        = 15'd0;
        bus.p4        = 15'd0;
        bus.alive     = 4'd0;

        // 1: reset values, then power-on sweep
        push_sweep();
        step();
        step();
        chk("rst_x", 32'(bus.x), 32'd0);
        chk("rst_plot", 32'(bus.plot), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_oob", 32'(bus.oob_err), 32'd0);
        resetn = 1'b1;
        wait_done(20000, n);
        chk("sweep_len", 32'(n), 32'd19201);
        chk("sweep_pix", 32'(pix_cnt), 32'd19200);
        chk("sweep_busy", 32'(bus.busy), 32'd0);
        step();
        chk("sweep_q", 32'(exp_q.size()), 32'd0);

        // 2: all alive, including the (159,119) corner
        bus.p1 = {8'd10, 7'd20};
        bus.p2 = {8'd0, 7'd0};
        bus.p3 = {8'd159, 7'd119};
        bus.p4 = {8'd150, 7'd100};
        bus.alive = 4'b1111;
        push_frame(bus.p1, bus.p2, bus.p3, bus.p4, bus.alive);
        tick_frame("t2");

        // 3: P2/P4 dead, P4 out of range but dead must not flag
        bus.alive = 4'b0101;
        bus.p2 = {8'd33, 7'd44};
        bus.p4 = {8'd170, 7'd125};
        push_frame(bus.p1, bus.p2, bus.p3, bus.p4, bus.alive);
        tick_frame("t3");
        chk("t3_oob", 32'(bus.oob_err), 32'd0);

        // 4: alive P2 out of range -> skipped slot, sticky oob_err
        bus.alive = 4'b1111;
        bus.p2 = {8'd200, 7'd5};
        bus.p4 = {8'd1, 7'd119};
        push_frame(bus.p1, bus.p2, bus.p3, bus.p4, bus.alive);
        tick_frame("t4");
        chk("t4_oob", 32'(bus.oob_err), 32'd1);
        bus.p2 = {8'd159, 7'd60};
        bus.p4 = {8'd160, 7'd0};
        bus.alive = 4'b0111;
        push_frame(bus.p1, bus.p2, bus.p3, bus.p4, bus.alive);
        tick_frame("t4b");
        chk("t4_oob_sticky", 32'(bus.oob_err), 32'd1);

        // 5: snapshot, one-deep pending tick, third tick dropped
        bus.alive = 4'b1111;
        bus.p1 = {8'd7, 7'd8};
        bus.p4 = {8'd90, 7'd91};
        push_frame(bus.p1, bus.p2, bus.p3, bus.p4, bus.alive);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        bus.p1 = {8'd120, 7'd3};
        push_frame(bus.p1, bus.p2, bus.p3, bus.p4, bus.alive);
        step();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        wait_done(20, n);
        chk("t5_first_lat", 32'(n), 32'd1);
        wait_done(20, n);
        chk("t5_second_lat", 32'(n), 32'd6);
        repeat (20) step();
        chk("t5_q", 32'(exp_q.size()), 32'd0);

        // 6a: clear_req and tick together -> sweep then frame
        bus.p1 = {8'd50, 7'd60};
        push_sweep();
        push_frame(bus.p1, bus.p2, bus.p3, bus.p4, bus.alive);
        bus.clear_req = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.clear_req = 1'b0;
        bus.tick = 1'b0;
        wait_done(20000, n);
        chk("t6_sweep_len", 32'(n), 32'd19201);
        wait_done(20, n);
        chk("t6_frame_lat", 32'(n), 32'd6);
        step();
        chk("t6_q", 32'(exp_q.size()), 32'd0);

        // 6b: reset during a sweep restarts it from (0,0)
        push_sweep();
        base = pix_cnt;
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        n = 0;
        while ((pix_cnt - base) < 5000 && n < 6000) begin
            step();
            n++;
        end
        chk("t6_reach5000", 32'(pix_cnt - base), 32'd5000);
        resetn = 1'b0;
        #1;
        chk("t6_rst_plot", 32'(bus.plot), 32'd0);
        chk("t6_rst_xy", 32'({bus.x, bus.y, bus.colour}), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd1);
        chk("t6_rst_oob", 32'(bus.oob_err), 32'd0);
        exp_q.delete();
        push_sweep();
        step();
        step();
        resetn = 1'b1;
        wait_done(20000, n);
        chk("t6_restart_len", 32'(n), 32'd19201);
        step();
        chk("t6_restart_q", 32'(exp_q.size()), 32'd0);
        chk("t6_restart_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
